// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding imem initiator feeding decode through a small in-order buffer.
// Redirects flush the buffer and discard any response still in flight.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_fault_o
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {FETCH, WAIT, HALT} state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } entry_t;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        discard_q, discard_d;

    entry_t             fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               full, aligned, fault_push, push, pop;
    entry_t             push_entry, head;

    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign aligned = (pc_q[1:0] == 2'b00);

    // A misaligned PC never reaches the bus; it becomes a fault entry instead.
    assign imem_req_o  = rst_ni && (state_q == FETCH) && !full && !redirect_i && aligned;
    assign imem_addr_o = pc_q;
    assign fault_push  = (state_q == FETCH) && !full && !redirect_i && !aligned;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        discard_d  = discard_q;
        push       = 1'b0;
        push_entry = '0;
        if (redirect_i) begin
            pc_d = redirect_pc_i;
            if (state_q == WAIT) begin
                // Response still owed: remember to swallow it when it shows up.
                if (imem_rvalid_i) begin
                    state_d   = FETCH;
                    discard_d = 1'b0;
                end else begin
                    discard_d = 1'b1;
                end
            end else begin
                state_d = FETCH;
            end
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (fault_push) begin
                        push       = 1'b1;
                        push_entry = '{pc: pc_q, instr: 32'h0, fault: 1'b1};
                        state_d    = HALT;
                    end else if (imem_req_o && imem_gnt_i) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + 32'd4;
                        state_d  = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        state_d = FETCH;
                        if (discard_q) begin
                            discard_d = 1'b0;
                        end else begin
                            push       = 1'b1;
                            push_entry = '{pc: req_pc_q, instr: imem_rdata_i, fault: 1'b0};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign pop = instr_valid_o && instr_ready_i && !redirect_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            req_pc_q  <= RESET_PC;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_pc_q  <= req_pc_d;
            discard_q <= discard_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (redirect_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset: outputs are masked while the buffer is empty.
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= push_entry;
    end

    assign head          = fifo_q[rd_ptr_q];
    assign instr_valid_o = (count_q != '0);
    assign instr_o       = instr_valid_o ? head.instr : 32'h0;
    assign instr_pc_o    = instr_valid_o ? head.pc    : 32'h0;
    assign instr_fault_o = instr_valid_o && head.fault;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch-side initiator that reads instruction memory and supplies the core's decode stage.
- Keeps a PC and issues word-aligned read requests over a req/gnt/rvalid memory handshake, with at most one request outstanding.
- Buffers returned words with their PCs in a small in-order FIFO.
- Handles branch/jump redirects: flushes the FIFO and drops any in-flight stale response.

Parameters:
- RESET_PC, 32'h0000_0000: PC fetched first after reset.
- FIFO_DEPTH, 2: instruction buffer entries, power of two, ≥ 2.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- imem_req_o  output  1  read request valid.
- imem_addr_o  output  32  request address = current fetch PC.
- imem_gnt_i  input  1  memory accepts the request this cycle.
- imem_rvalid_i  input  1  read data valid; earliest one cycle after gnt.
- imem_rdata_i  input  32  read data.
- redirect_i  input  1  load a new fetch PC (branch/jump/trap).
- redirect_pc_i  input  32  redirect target.
- instr_valid_o  output  1  FIFO head valid.
- instr_ready_i  input  1  decode consumes the head this cycle.
- instr_o  output  32  instruction word at the head.
- instr_pc_o  output  32  PC of the head.
- instr_fault_o  output  1  head is a misaligned-fetch fault entry.

Behaviour:
- Reset (asynchronous, rst_ni low):
  - fetch PC ← RESET_PC, state ← FETCH, FIFO emptied, discard flag cleared.
  - imem_req_o = 0, instr_valid_o = 0, instr_o = 0, instr_pc_o = 0, instr_fault_o = 0.
  - All of these hold immediately, with no clock edge needed.
- States:
  - FETCH: imem_req_o = 1 iff FIFO count < FIFO_DEPTH, redirect_i = 0 and state is not HALT. imem_addr_o = PC. On req & gnt: latch req_pc ← PC, PC ← PC + 4 (wraps modulo 2^32), go to WAIT.
  - WAIT: imem_req_o = 0. On imem_rvalid_i: if the discard flag is clear, push {req_pc, imem_rdata_i, fault=0}; if it is set, drop the data and clear the flag. Then go to FETCH.
  - HALT: entered after a fault entry is pushed. No requests are issued. Left only via redirect.
- Throughput: with zero-wait memory (gnt = 1, rvalid the next cycle), one instruction is pushed every 2 cycles.
- FIFO:
  - In order. instr_o, instr_pc_o and instr_fault_o show the head combinationally. instr_valid_o = count ≠ 0.
  - Pop on instr_valid_o & instr_ready_i.
  - A push and a pop in the same cycle are both allowed; count is unchanged.
  - A push never occurs while full: requests are gated by the count, and only one request is outstanding.
  - instr_ready_i while empty has no effect.
- Redirect (redirect_i = 1 at a rising edge):
  - FIFO flushed. A same-cycle pop or push is cancelled; redirect wins.
  - PC ← redirect_pc_i.
  - If in WAIT with rvalid not present this cycle: set the discard flag, stay in WAIT.
  - If in WAIT with rvalid present this cycle: drop the data, go to FETCH.
  - From HALT: go to FETCH.
  - imem_req_o is forced to 0 in the redirect cycle, so a gnt in that cycle is ignored.
- Misaligned target (redirect_pc_i[1:0] ≠ 0), once in FETCH with FIFO space:
  - Issue no request.
  - Push {pc, 32'h0, fault=1}, then enter HALT.
- imem_rvalid_i outside WAIT is ignored.
- Redirect during reset is ignored.
- Addresses above the memory range are still issued as requests. The memory's out-of-range data (0) is passed through unmodified, with instr_fault_o = 0.

Test Plan:
1. Release reset; gnt = 1, rvalid one cycle after each gnt, rdata = addr ^ 32'hA5A5_0000, ready = 1. Required: heads at PC 0x0, 0x4, 0x8 with matching words, one new instruction every 2 cycles, no gaps beyond that.
2. Hold ready = 0 with the same memory. Required: exactly 2 entries (PC 0x0, 0x4) buffered, then imem_req_o stays 0. Raise ready: 0x0, then 0x4, then 0x8 delivered in order.
3. gnt at PC 0x8; redirect to 0x100 the next cycle with rvalid delayed by 3 cycles. Required: the 0x8 data is discarded. The next delivered head is PC 0x100 with 0x100's word. No 0x8 entry appears.
4. Redirect to 0x40 in the same cycle as instr_valid & ready with 2 entries queued. Required: instr_valid_o = 0 next cycle. The first new head is PC 0x40.
5. Redirect to 0x102. Required: a head with instr_pc_o = 0x102, instr_o = 0, instr_fault_o = 1. imem_req_o stays 0 for ≥ 10 cycles, until a redirect to 0x200 resumes fetching at 0x200.
6. Assert rst_ni low mid-WAIT (between gnt and rvalid), then deliver a late rvalid. Required: all outputs 0 immediately, the late rvalid is ignored, and after release the first request is to RESET_PC.
